// File: rtl/rvi_bj_redirect_ctrl.sv
// rvi_bj_redirect_ctrl: branch/jump resolution check behind the execute stage.
// Compares the resolved outcome with the fetch prediction. On a mispredict it
// issues a one-cycle flush and holds a registered redirect until fetch takes it.
// It also emits predictor updates, a misaligned-target exception and saturating
// branch/mispredict counters.
// Build option: define RVI_BJ_RVC_EN to allow 2-byte aligned targets. Without
// it, targets must be 4-byte aligned.
module rvi_bj_redirect_ctrl #(
  parameter int unsigned RV64      = 0,
  parameter int unsigned CPU_WIDTH = 32 * (RV64 + 1),
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exVld,
  output logic                 exRdy,
  input  logic                 branch,
  input  logic                 jump,
  input  logic [1:0]           bjEn,
  input  logic [CPU_WIDTH-1:0] pc,
  input  logic [CPU_WIDTH-1:0] tgtAddr,
  input  logic [CPU_WIDTH-1:0] linkPc,
  input  logic                 predTaken,
  input  logic [CPU_WIDTH-1:0] predTgt,
  output logic                 flush,
  output logic                 redirVld,
  input  logic                 redirRdy,
  output logic [CPU_WIDTH-1:0] redirAddr,
  output logic                 updVld,
  output logic [CPU_WIDTH-1:0] updPc,
  output logic                 updTaken,
  output logic [CPU_WIDTH-1:0] updTgt,
  output logic                 excVld,
  output logic [CPU_WIDTH-1:0] excTval,
  output logic [CNT_W-1:0]     brCnt,
  output logic [CNT_W-1:0]     mispCnt
);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

  state_e               stateQ, stateD;
  logic [CPU_WIDTH-1:0] redirAddrQ, redirAddrD;
  logic                 flushQ;
  logic                 updVldQ, updTakenQ;
  logic [CPU_WIDTH-1:0] updPcQ, updTgtQ;
  logic                 excVldQ;
  logic [CPU_WIDTH-1:0] excTvalQ;
  logic [CNT_W-1:0]     brCntQ, mispCntQ;

  logic                 accept;
  logic                 actTaken;
  logic [CPU_WIDTH-1:0] actTgt;
  logic                 mispredict;
  logic                 misal;

  // Resolve the outcome and classify the accepted instruction.
  always_comb begin
    accept     = exVld & exRdy & (branch | jump);
    actTaken   = |bjEn;
    actTgt     = actTaken ? tgtAddr : linkPc;
    mispredict = (actTaken != predTaken) | (actTaken & predTaken & (tgtAddr != predTgt));
`ifdef RVI_BJ_RVC_EN
    misal      = actTaken & tgtAddr[0];
`else
    misal      = actTaken & (tgtAddr[1] | tgtAddr[0]);
`endif
  end

  // Redirect FSM next state; the redirect target is captured only on entry to PEND.
  always_comb begin
    stateD     = stateQ;
    redirAddrD = redirAddrQ;
    unique case (stateQ)
      StIdle: begin
        if (accept && mispredict && !misal) begin
          stateD     = StPend;
          redirAddrD = actTgt;
        end
      end
      StPend: begin
        if (redirRdy) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // FSM state and held redirect address.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      redirAddrQ <= '0;
    end else begin
      stateQ     <= stateD;
      redirAddrQ <= redirAddrD;
    end
  end

  // One-cycle flush, predictor update and exception pulses for cycle N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      flushQ    <= 1'b0;
      updVldQ   <= 1'b0;
      updPcQ    <= '0;
      updTakenQ <= 1'b0;
      updTgtQ   <= '0;
      excVldQ   <= 1'b0;
      excTvalQ  <= '0;
    end else begin
      // A misaligned target also kills younger instructions, but never redirects.
      flushQ  <= accept & (mispredict | misal);
      updVldQ <= accept & ~misal;
      excVldQ <= accept & misal;
      if (accept && !misal) begin
        updPcQ    <= pc;
        updTakenQ <= actTaken;
        updTgtQ   <= actTgt;
      end
      if (accept && misal) begin
        excTvalQ <= tgtAddr;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      brCntQ   <= '0;
      mispCntQ <= '0;
    end else begin
      if (accept && (brCntQ != '1)) begin
        brCntQ <= brCntQ + CntOne;
      end
      if (accept && mispredict && !misal && (mispCntQ != '1)) begin
        mispCntQ <= mispCntQ + CntOne;
      end
    end
  end

  assign exRdy     = (stateQ == StIdle);
  assign redirVld  = (stateQ == StPend);
  assign redirAddr = redirAddrQ;
  assign flush     = flushQ;
  assign updVld    = updVldQ;
  assign updPc     = updPcQ;
  assign updTaken  = updTakenQ;
  assign updTgt    = updTgtQ;
  assign excVld    = excVldQ;
  assign excTval   = excTvalQ;
  assign brCnt     = brCntQ;
  assign mispCnt   = mispCntQ;

endmodule

// File: tb/tb_rvi_bj_redirect_ctrl.sv
// Scoreboard bench for rvi_bj_redirect_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them as the DUT presents output.
module tb_rvi_bj_redirect_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         exVld = 1'b0, branch = 1'b0, jump = 1'b0, predTaken = 1'b0, redirRdy = 1'b0;
  logic [1:0]   bjEn = 2'b00;
  logic [W-1:0] pc = '0, tgtAddr = '0, linkPc = '0, predTgt = '0;

  logic         exRdy, flush, redirVld, updVld, updTaken, excVld;
  logic [W-1:0] redirAddr, updPc, updTgt, excTval, brCnt, mispCnt;

  logic         sExRdy, sFlush, sRedirVld, sUpdVld, sUpdTaken, sExcVld;
  logic [W-1:0] sRedirAddr, sUpdPc, sUpdTgt, sExcTval;
  logic [3:0]   sBrCnt, sMispCnt;

  always #5 clk = ~clk;

  rvi_bj_redirect_ctrl dut (
    .clk(clk), .rst(rst), .exVld(exVld), .exRdy(exRdy), .branch(branch), .jump(jump),
    .bjEn(bjEn), .pc(pc), .tgtAddr(tgtAddr), .linkPc(linkPc), .predTaken(predTaken),
    .predTgt(predTgt), .flush(flush), .redirVld(redirVld), .redirRdy(redirRdy),
    .redirAddr(redirAddr), .updVld(updVld), .updPc(updPc), .updTaken(updTaken),
    .updTgt(updTgt), .excVld(excVld), .excTval(excTval), .brCnt(brCnt), .mispCnt(mispCnt)
  );

  rvi_bj_redirect_ctrl #(.CNT_W(4)) satDut (
    .clk(clk), .rst(rst), .exVld(exVld), .exRdy(sExRdy), .branch(branch), .jump(jump),
    .bjEn(bjEn), .pc(pc), .tgtAddr(tgtAddr), .linkPc(linkPc), .predTaken(predTaken),
    .predTgt(predTgt), .flush(sFlush), .redirVld(sRedirVld), .redirRdy(redirRdy),
    .redirAddr(sRedirAddr), .updVld(sUpdVld), .updPc(sUpdPc), .updTaken(sUpdTaken),
    .updTgt(sUpdTgt), .excVld(sExcVld), .excTval(sExcTval), .brCnt(sBrCnt), .mispCnt(sMispCnt)
  );

  typedef struct packed {
    logic [W-1:0] pc;
    logic         taken;
    logic [W-1:0] tgt;
  } upd_t;

  typedef struct {
    string        name;
    logic         rdy;
    logic         rv;
    logic         rstChk;
    logic [W-1:0] br;
    logic [W-1:0] mi;
    logic [3:0]   sat;
  } chk_t;

  upd_t         updQ[$];
  logic [W-1:0] excQ[$];
  logic         flushQ[$];
  logic [W-1:0] redirQ[$];
  chk_t         chkQ[$];

  int nTests = 0;
  int nFail  = 0;
  bit done = 1'b0, reported = 1'b0;

  // Bench-side expected counters (stimulus process only).
  int unsigned expBr = 0, expMisp = 0, expSat = 0;

  localparam int KIgnored = -1, KCorrect = 0, KRedirect = 1, KExc = 2;

  // ---------------- monitor / checker ----------------
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  logic         holdPrev = 1'b0;
  logic [W-1:0] prevAddr = '0;

  always @(negedge clk) begin
    if (rst) begin
      redirQ.delete();
      holdPrev = 1'b0;
    end else begin
      if (updVld) begin
        if (updQ.size() == 0) check("updVld_unexpected", 1, 0);
        else begin
          upd_t e;
          e = updQ.pop_front();
          check("upd.pc", updPc, e.pc);
          check("upd.taken", {31'b0, updTaken}, {31'b0, e.taken});
          check("upd.tgt", updTgt, e.tgt);
        end
      end
      if (excVld) begin
        if (excQ.size() == 0) check("excVld_unexpected", 1, 0);
        else check("exc.tval", excTval, excQ.pop_front());
      end
      if (flush) begin
        if (flushQ.size() == 0) check("flush_unexpected", 1, 0);
        else check("flush.redirVld", {31'b0, redirVld}, {31'b0, flushQ.pop_front()});
      end
      if (redirVld && redirRdy) begin
        if (redirQ.size() == 0) check("redir_unexpected", 1, 0);
        else check("redir.addr", redirAddr, redirQ.pop_front());
      end
      if (holdPrev) begin
        check("redir_hold.vld", {31'b0, redirVld}, 1);
        check("redir_hold.addr", redirAddr, prevAddr);
      end
      holdPrev = redirVld && !redirRdy;
      prevAddr = redirAddr;
      while (chkQ.size() > 0) begin
        chk_t c;
        c = chkQ.pop_front();
        check({c.name, ".exRdy"}, {31'b0, exRdy}, {31'b0, c.rdy});
        check({c.name, ".redirVld"}, {31'b0, redirVld}, {31'b0, c.rv});
        check({c.name, ".brCnt"}, brCnt, c.br);
        check({c.name, ".mispCnt"}, mispCnt, c.mi);
        check({c.name, ".satBrCnt"}, {28'b0, sBrCnt}, {28'b0, c.sat});
        if (c.rstChk) begin
          check({c.name, ".flush"}, {31'b0, flush}, 0);
          check({c.name, ".updVld"}, {31'b0, updVld}, 0);
          check({c.name, ".excVld"}, {31'b0, excVld}, 0);
          check({c.name, ".updTaken"}, {31'b0, updTaken}, 0);
          check({c.name, ".redirAddr"}, redirAddr, 0);
          check({c.name, ".updPc"}, updPc, 0);
          check({c.name, ".updTgt"}, updTgt, 0);
          check({c.name, ".excTval"}, excTval, 0);
        end
      end
    end
    if (done && !reported) begin
      check("updQ_left", W'(updQ.size()), 0);
      check("excQ_left", W'(excQ.size()), 0);
      check("flushQ_left", W'(flushQ.size()), 0);
      check("redirQ_left", W'(redirQ.size()), 0);
      reported = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic iBr, input logic iJp, input logic [1:0] iEn,
                       input logic [W-1:0] iPc, input logic [W-1:0] iTgt,
                       input logic [W-1:0] iLnk, input logic iPt, input logic [W-1:0] iPtg,
                       input int kind, input logic eTk, input logic [W-1:0] eTgt);
    upd_t u;
    @(posedge clk); #1;
    exVld = 1'b1; branch = iBr; jump = iJp; bjEn = iEn; pc = iPc;
    tgtAddr = iTgt; linkPc = iLnk; predTaken = iPt; predTgt = iPtg;
    if (kind != KIgnored) begin
      expBr++;
      if (expSat < 15) expSat++;
    end
    u.pc = iPc; u.taken = eTk; u.tgt = eTgt;
    case (kind)
      KCorrect: updQ.push_back(u);
      KRedirect: begin
        expMisp++;
        updQ.push_back(u);
        flushQ.push_back(1'b1);
        redirQ.push_back(eTgt);
      end
      KExc: begin
        excQ.push_back(eTgt);
        flushQ.push_back(1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      exVld = 1'b0; branch = 1'b0; jump = 1'b0;
    end
  endtask

  task automatic expect_state(input string nm, input logic rdy, input logic rv,
                              input logic rstChk);
    chk_t c;
    c.name = nm; c.rdy = rdy; c.rv = rv; c.rstChk = rstChk;
    c.br = W'(expBr); c.mi = W'(expMisp); c.sat = 4'(expSat);
    chkQ.push_back(c);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    rst = 1'b1; exVld = 1'b0; branch = 1'b0; jump = 1'b0;
    expBr = 0; expMisp = 0; expSat = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_state(nm, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic         rvcRdy, rvcRv;
    do_reset("reset");
    idle(1);

    // Correctly predicted taken branch.
    issue(1, 0, 2'b10, 32'h100, 32'h140, 32'h104, 1, 32'h140, KCorrect, 1, 32'h140);
    idle(1);
    expect_state("t1", 1, 0, 0);

    // Predicted taken, not taken: redirect to link PC, accepted in the first PEND cycle.
    redirRdy = 1'b1;
    issue(1, 0, 2'b00, 32'h200, 32'h240, 32'h204, 1, 32'h240, KRedirect, 0, 32'h204);
    idle(1);
    expect_state("t2_pend", 0, 1, 0);
    idle(1);
    expect_state("t2_idle", 1, 0, 0);
    redirRdy = 1'b0;

    // Jump to wrong target; fetch stalls three cycles, EX offers are ignored meanwhile.
    issue(0, 1, 2'b01, 32'h2f0, 32'h380, 32'h2f4, 1, 32'h300, KRedirect, 1, 32'h380);
    idle(1);
    expect_state("t3_pend", 0, 1, 0);
    issue(1, 0, 2'b00, 32'h2f8, 32'h3a0, 32'h2fc, 1, 32'h3a0, KIgnored, 0, 0);
    issue(0, 1, 2'b01, 32'h2fc, 32'h3c0, 32'h300, 0, 32'h000, KIgnored, 0, 0);
    @(posedge clk); #1;
    exVld = 1'b0; branch = 1'b0; jump = 1'b0; redirRdy = 1'b1;
    expect_state("t3_last", 0, 1, 0);
    @(posedge clk); #1;
    redirRdy = 1'b0;
    expect_state("t3_idle", 1, 0, 0);

    // Target with bit 1 set: legal only with compressed support.
    redirRdy = 1'b1;
`ifdef RVI_BJ_RVC_EN
    issue(0, 1, 2'b01, 32'h3f0, 32'h302, 32'h3f4, 1, 32'h300, KRedirect, 1, 32'h302);
    rvcRdy = 1'b0; rvcRv = 1'b1;
`else
    issue(0, 1, 2'b01, 32'h3f0, 32'h302, 32'h3f4, 1, 32'h300, KExc, 1, 32'h302);
    rvcRdy = 1'b1; rvcRv = 1'b0;
`endif
    idle(1);
    expect_state("t4_n1", rvcRdy, rvcRv, 0);
    idle(1);
    expect_state("t4_n2", 1, 0, 0);
    redirRdy = 1'b0;

    // Odd target is misaligned in either build; mispredict not counted.
    issue(1, 0, 2'b10, 32'h500, 32'h501, 32'h504, 0, 32'h000, KExc, 1, 32'h501);
    idle(1);
    expect_state("t4b", 1, 0, 0);

    // Correct not-taken branch, then a non-branch that must be ignored.
    issue(1, 0, 2'b00, 32'h580, 32'h5c0, 32'h584, 0, 32'h5c0, KCorrect, 0, 32'h584);
    issue(0, 0, 2'b11, 32'h584, 32'h5c8, 32'h588, 1, 32'h000, KIgnored, 0, 0);
    idle(1);
    expect_state("t6", 1, 0, 0);

    // Predicted not taken, actually taken.
    redirRdy = 1'b1;
    issue(1, 0, 2'b01, 32'h600, 32'h680, 32'h604, 0, 32'h000, KRedirect, 1, 32'h680);
    idle(2);
    expect_state("t7", 1, 0, 0);
    redirRdy = 1'b0;

    // Reset on the second PEND cycle discards the pending redirect.
    issue(1, 0, 2'b00, 32'h700, 32'h740, 32'h704, 1, 32'h740, KRedirect, 0, 32'h704);
    idle(1);
    expect_state("t5_pend", 0, 1, 0);
    do_reset("t5_rst");

    // Twenty back-to-back correct branches; the 4-bit counter sticks at 15.
    for (int i = 0; i < 20; i++) begin
      issue(1, 0, 2'b10, 32'h800 + 32'(4 * i), 32'h900, 32'h804 + 32'(4 * i), 1, 32'h900,
            KCorrect, 1, 32'h900);
    end
    idle(1);
    expect_state("t8_sat", 1, 0, 0);
    idle(3);

    done = 1'b1;
    repeat (3) @(posedge clk);
    if (!reported) $display("FAIL final_report: got 0 expected 1");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
